uart_tx_arbiter_n: RTL and testbench



---
 rtl/uart_tx_arbiter_n.sv | 138 +++++++++++++
 tb/tb_uart_tx_arbiter_n.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter_n.sv
// N-channel frame-safe UART TX arbiter: merges several TX lines onto one pin, handing the line
// to one source at a time and releasing it only after a guard time of idle-high line.
module uart_tx_arbiter_n #(
  parameter int unsigned          NUM_CH       = 4,
  parameter logic [NUM_CH-1:0]    PASSIVE_MASK = 4'b0001,
  parameter int unsigned          ARB_MODE     = 0,
  parameter int unsigned          GUARD_CYCLES = 1000,
  localparam int unsigned         OW           = $clog2(NUM_CH),
  localparam int unsigned         CW           = $clog2(GUARD_CYCLES + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] tx_i,
  input  logic [NUM_CH-1:0] req_i,
  output logic [NUM_CH-1:0] grant_o,
  output logic              tx_o,
  output logic              busy_o,
  output logic [OW-1:0]     owner_o,
  output logic [NUM_CH-1:0] collision_o
);

  typedef enum logic [1:0] {StIdle, StOwn, StRelease} state_e;

  state_e            state_q, state_d;
  logic [OW-1:0]     owner_q, owner_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [OW-1:0]     ptr_q, ptr_d;
  logic [NUM_CH-1:0] tx_prev_q;
  logic [NUM_CH-1:0] grant_q, grant_d;
  logic              tx_q, tx_d;
  logic [NUM_CH-1:0] coll_q, coll_d;

  logic [NUM_CH-1:0] eff_req;
  logic              win_valid;
  logic [OW-1:0]     winner;
  logic [OW:0]       scan_sum;
  logic [OW-1:0]     scan_idx;

  // Passive channels request with their start bit; active ones with req_i.
  assign eff_req = (PASSIVE_MASK & ~tx_i) | (~PASSIVE_MASK & req_i);

  // Loops run from the top down so the last hit (lowest index / nearest to ptr) wins.
  always_comb begin
    win_valid = 1'b0;
    winner    = '0;
    scan_sum  = '0;
    scan_idx  = '0;
    if (ARB_MODE == 0) begin
      for (int i = NUM_CH - 1; i >= 0; i--) begin
        if (eff_req[i]) begin
          win_valid = 1'b1;
          winner    = OW'(i);
        end
      end
    end else begin
      for (int k = NUM_CH - 1; k >= 0; k--) begin
        scan_sum = {1'b0, ptr_q} + (OW + 1)'(k);
        if (scan_sum >= (OW + 1)'(NUM_CH)) scan_sum = scan_sum - (OW + 1)'(NUM_CH);
        scan_idx = scan_sum[OW-1:0];
        if (eff_req[scan_idx]) begin
          win_valid = 1'b1;
          winner    = scan_idx;
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      StIdle: begin
        if (win_valid) begin
          state_d = StOwn;
          owner_d = winner;
          cnt_d   = '0;
        end
      end
      StOwn: begin
        if (!tx_i[owner_q]) begin
          cnt_d = '0;
        end else if (cnt_q != CW'(GUARD_CYCLES)) begin
          cnt_d = cnt_q + 1'b1;
        end
        if (cnt_q == CW'(GUARD_CYCLES) && (PASSIVE_MASK[owner_q] || !req_i[owner_q])) begin
          state_d = StRelease;
        end
      end
      StRelease: begin
        state_d = StIdle;
        ptr_d   = (owner_q == OW'(NUM_CH - 1)) ? '0 : owner_q + 1'b1;
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs are registered from the next state so a winning start bit is forwarded at once.
  always_comb begin
    grant_d = '0;
    tx_d    = 1'b1;
    if (state_d == StOwn) begin
      grant_d[owner_d] = 1'b1;
      tx_d             = tx_i[owner_d];
    end
    coll_d = PASSIVE_MASK & tx_prev_q & ~tx_i & ~grant_q & ~grant_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      owner_q   <= '0;
      cnt_q     <= '0;
      ptr_q     <= '0;
      tx_prev_q <= '1;
      grant_q   <= '0;
      tx_q      <= 1'b1;
      coll_q    <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      cnt_q     <= cnt_d;
      ptr_q     <= ptr_d;
      tx_prev_q <= tx_i;
      grant_q   <= grant_d;
      tx_q      <= tx_d;
      coll_q    <= coll_d;
    end
  end

  assign grant_o     = grant_q;
  assign tx_o        = tx_q;
  assign busy_o      = (state_q == StOwn);
  assign owner_o     = owner_q;
  assign collision_o = coll_q;

endmodule

// File: tb/tb_uart_tx_arbiter_n.sv
// Bench for uart_tx_arbiter_n: fixed-priority and round-robin instances share stimulus and are
// compared each cycle against a cycle-level reference model, plus directed scenario checks.
module tb_uart_tx_arbiter_n;
  localparam int N = 4;
  localparam int G = 8;
  localparam logic [3:0] PM = 4'b0001;
  localparam int S_IDLE = 0, S_OWN = 1, S_REL = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] tx, req;
  logic [3:0] g_fp, c_fp, g_rr, c_rr;
  logic       t_fp, b_fp, t_rr, b_rr;
  logic [1:0] o_fp, o_rr;

  always #5 clk = ~clk;

  uart_tx_arbiter_n #(.NUM_CH(4), .PASSIVE_MASK(4'b0001), .ARB_MODE(0), .GUARD_CYCLES(8)) u_fp (
    .clk(clk), .rst_n(rst_n), .tx_i(tx), .req_i(req), .grant_o(g_fp), .tx_o(t_fp),
    .busy_o(b_fp), .owner_o(o_fp), .collision_o(c_fp)
  );

  uart_tx_arbiter_n #(.NUM_CH(4), .PASSIVE_MASK(4'b0001), .ARB_MODE(1), .GUARD_CYCLES(8)) u_rr (
    .clk(clk), .rst_n(rst_n), .tx_i(tx), .req_i(req), .grant_o(g_rr), .tx_o(t_rr),
    .busy_o(b_rr), .owner_o(o_rr), .collision_o(c_rr)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  // Reference model: index 0 = fixed priority, index 1 = round-robin.
  int         m_state[2], m_owner[2], m_cnt[2], m_ptr[2];
  logic [3:0] m_prev[2];
  logic [3:0] e_grant[2], e_coll[2];
  logic       e_tx[2], e_busy[2];
  int         e_owner[2];

  function automatic int pick(input int k, input logic [3:0] eff);
    for (int j = 0; j < N; j++) begin
      int idx;
      idx = (k == 0) ? j : (m_ptr[k] + j) % N;
      if (eff[idx]) return idx;
    end
    return 0;
  endfunction

  task automatic model_step(input logic r, input logic [3:0] t, input logic [3:0] q);
    for (int k = 0; k < 2; k++) begin
      if (!r) begin
        m_state[k] = S_IDLE; m_owner[k] = 0; m_cnt[k] = 0; m_ptr[k] = 0; m_prev[k] = 4'hF;
        e_grant[k] = 4'h0; e_coll[k] = 4'h0; e_tx[k] = 1'b1; e_busy[k] = 1'b0; e_owner[k] = 0;
      end else begin
        logic [3:0] eff;
        int ns, no, nc;
        eff = (PM & ~t) | (~PM & q);
        ns = m_state[k]; no = m_owner[k]; nc = m_cnt[k];
        if (m_state[k] == S_IDLE) begin
          if (eff != 0) begin ns = S_OWN; no = pick(k, eff); nc = 0; end
        end else if (m_state[k] == S_OWN) begin
          nc = t[m_owner[k]] ? ((m_cnt[k] < G) ? m_cnt[k] + 1 : G) : 0;
          if (m_cnt[k] == G && (PM[m_owner[k]] || !q[m_owner[k]])) ns = S_REL;
        end else begin
          ns = S_IDLE;
          m_ptr[k] = (m_owner[k] + 1) % N;
        end
        for (int i = 0; i < N; i++) begin
          logic mine;
          mine = (m_state[k] == S_OWN && m_owner[k] == i) || (ns == S_OWN && no == i);
          e_coll[k][i] = PM[i] && m_prev[k][i] && !t[i] && !mine;
        end
        e_tx[k]    = (ns == S_OWN) ? t[no] : 1'b1;
        e_grant[k] = (ns == S_OWN) ? 4'(1 << no) : 4'h0;
        e_busy[k]  = (ns == S_OWN);
        e_owner[k] = no;
        m_state[k] = ns; m_owner[k] = no; m_cnt[k] = nc; m_prev[k] = t;
      end
    end
  endtask

  task automatic cyc(input logic r, input logic [3:0] t, input logic [3:0] q);
    rst_n = r; tx = t; req = q;
    model_step(r, t, q);
    @(posedge clk);
    #1;
    check_eq("fp_grant", g_fp, e_grant[0]);
    check_eq("fp_tx", t_fp, e_tx[0]);
    check_eq("fp_busy", b_fp, e_busy[0]);
    check_eq("fp_owner", o_fp, e_owner[0]);
    check_eq("fp_coll", c_fp, e_coll[0]);
    check_eq("rr_grant", g_rr, e_grant[1]);
    check_eq("rr_tx", t_rr, e_tx[1]);
    check_eq("rr_busy", b_rr, e_busy[1]);
    check_eq("rr_owner", o_rr, e_owner[1]);
    check_eq("rr_coll", c_rr, e_coll[1]);
  endtask

  task automatic wait_fp(input logic [3:0] t, input logic [3:0] q, input logic [3:0] want,
                         input string tag);
    for (int n = 0; n < 40 && g_fp != want; n++) begin
      cyc(1'b1, t, q);
      check_eq("fp_onehot", 32'($countones(g_fp) <= 1), 1);
    end
    check_eq(tag, g_fp, want);
  endtask

  task automatic wait_rr(input logic [3:0] t, input logic [3:0] q, input logic [3:0] want,
                         input string tag);
    for (int n = 0; n < 40 && g_rr != want; n++) cyc(1'b1, t, q);
    check_eq(tag, g_rr, want);
  endtask

  initial begin
    logic [3:0] t, q;
    int low_pct;

    // Reset with all lines low, then the passive channel 0 wins straight away.
    repeat (3) cyc(1'b0, 4'b0000, 4'b0000);
    check_eq("rst_tx", t_fp, 1);
    check_eq("rst_grant", g_fp, 4'b0000);
    check_eq("rst_busy", b_fp, 0);
    cyc(1'b1, 4'b0000, 4'b0000);
    check_eq("post_rst_grant", g_fp, 4'b0001);
    wait_fp(4'b1111, 4'b0000, 4'b0000, "fp_release0");
    cyc(1'b1, 4'b1111, 4'b0000);

    // Passive start bit.
    cyc(1'b1, 4'b1110, 4'b0000);
    check_eq("pas_grant", g_fp, 4'b0001);
    check_eq("pas_busy", b_fp, 1);
    check_eq("pas_tx", t_fp, 0);
    cyc(1'b1, 4'b1111, 4'b0000);
    check_eq("pas_lag", t_fp, 1);
    cyc(1'b1, 4'b1110, 4'b0000);
    wait_fp(4'b1111, 4'b0000, 4'b0000, "pas_release");
    cyc(1'b1, 4'b1111, 4'b0000);

    // Fixed priority between two active requests.
    cyc(1'b1, 4'b1111, 4'b1100);
    check_eq("fp_prio_ch2", g_fp, 4'b0100);
    repeat (3) cyc(1'b1, 4'b1111, 4'b1100);
    wait_fp(4'b1111, 4'b1000, 4'b1000, "fp_then_ch3");
    wait_fp(4'b1111, 4'b0000, 4'b0000, "fp_release3");
    cyc(1'b1, 4'b1111, 4'b0000);

    // Collision: ch2 owns, passive ch0 starts a frame.
    cyc(1'b1, 4'b1111, 4'b0100);
    check_eq("col_owner", g_fp, 4'b0100);
    cyc(1'b1, 4'b1110, 4'b0100);
    check_eq("col_pulse", c_fp, 4'b0001);
    check_eq("col_tx_hi", t_fp, 1);
    cyc(1'b1, 4'b1110, 4'b0100);
    check_eq("col_once", c_fp, 4'b0000);
    cyc(1'b1, 4'b1010, 4'b0100);
    check_eq("col_tx_lo", t_fp, 0);
    wait_fp(4'b1111, 4'b0000, 4'b0000, "col_release");
    cyc(1'b1, 4'b1111, 4'b0000);

    // Reset in the middle of a ch1 frame.
    cyc(1'b1, 4'b1111, 4'b0010);
    check_eq("mid_owner", g_fp, 4'b0010);
    cyc(1'b1, 4'b1101, 4'b0010);
    check_eq("mid_tx_lo", t_fp, 0);
    cyc(1'b0, 4'b1101, 4'b0010);
    check_eq("mid_rst_tx", t_fp, 1);
    check_eq("mid_rst_grant", g_fp, 4'b0000);
    check_eq("mid_rst_busy", b_fp, 0);
    cyc(1'b1, 4'b1111, 4'b0000);
    check_eq("mid_idle", g_fp, 4'b0000);

    // Round-robin rotation from a fresh reset.
    repeat (2) cyc(1'b0, 4'b1111, 4'b0000);
    cyc(1'b1, 4'b1111, 4'b1110);
    check_eq("rr_first_ch1", g_rr, 4'b0010);
    wait_rr(4'b1111, 4'b1100, 4'b0100, "rr_then_ch2");
    wait_rr(4'b1111, 4'b1010, 4'b1000, "rr_then_ch3");
    wait_rr(4'b1111, 4'b0110, 4'b0010, "rr_wrap_ch1");

    // Randomised traffic against the model.
    q = 4'b0000;
    low_pct = 0;
    for (int c = 0; c < 3000; c++) begin
      if (c % 200 == 0) low_pct = (c / 200) % 3 == 0 ? 0 : ((c / 200) % 3 == 1 ? 5 : 30);
      for (int i = 0; i < N; i++) begin
        t[i] = ($urandom_range(0, 99) < low_pct) ? 1'b0 : 1'b1;
        if ($urandom_range(0, 15) == 0) q[i] = ~q[i];
      end
      cyc(($urandom_range(0, 599) != 0), t, q);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
